axi2apb_ctrl: RTL and testbench
===============================

Name: axi2apb_ctrl

Overview:
- Sequencer behind the AXI-to-APB command FIFO. Pops one command at a time and runs exactly one APB transfer for it.
- For writes, takes the single W beat; returns the response on B (writes) or R (reads).
- Pulses finish_wr/finish_rd to retire the command.
- Adds a PREADY timeout so a hung APB slave cannot stall the AXI side.

Parameters:
- AXI_ID_WIDTH, 6, width of cmd_id/BID/RID
- APB_ADDR_WIDTH, 12, APB slave window; cmd_addr/PADDR are APB_ADDR_WIDTH+4 bits
- TIMEOUT, 255, ACCESS cycles without PREADY before forced SLVERR; 0 disables timeout
- TIMEOUT_WIDTH, 8, timeout counter width; must hold TIMEOUT

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- cmd_empty  in  1  command FIFO empty
- cmd_read  in  1  head command is a read
- cmd_id  in  AXI_ID_WIDTH  head command ID
- cmd_addr  in  APB_ADDR_WIDTH+4  head command address
- cmd_err  in  1  head command unsupported (size/len)
- finish_wr  out  1  pop strobe, write retired
- finish_rd  out  1  pop strobe, read retired
- WDATA  in  32  AXI write data
- WSTRB  in  4  AXI write strobes
- WVALID  in  1  AXI W valid
- WREADY  out  1  AXI W ready
- BID  out  AXI_ID_WIDTH  write response ID
- BRESP  out  2  write response code
- BVALID  out  1  B valid
- BREADY  in  1  B ready
- RID  out  AXI_ID_WIDTH  read response ID
- RDATA  out  32  read data
- RRESP  out  2  read response code
- RLAST  out  1  last beat of read
- RVALID  out  1  R valid
- RREADY  in  1  R ready
- PADDR  out  APB_ADDR_WIDTH+4  APB address
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PWDATA  out  32  APB write data
- PSTRB  out  4  APB write strobes
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB error
- PRDATA  in  32  APB read data

Behaviour:
- Reset (asynchronous, any state, mid-transfer included):
  - state=IDLE.
  - PSEL, PENABLE, PWRITE, WREADY, BVALID, RVALID = 0.
  - PADDR, PWDATA, PSTRB, RDATA, BID, RID, BRESP, RRESP, timeout counter = 0.
  - RLAST is constant 1.
  - No finish pulse is issued for an aborted command; the FIFO is reset by the same reset.
- Registered states: IDLE, WDATA, SETUP, ACCESS, RESP.
- IDLE:
  - If !cmd_empty, latch cmd_id, cmd_addr, cmd_read, cmd_err.
  - Write -> WDATA.
  - Read without error -> SETUP.
  - Read with cmd_err -> RESP with RRESP=2'b10, RDATA=0; no APB cycle.
- WDATA:
  - WREADY=1 (combinational from state).
  - On WVALID&WREADY, capture WDATA/WSTRB into PWDATA/PSTRB.
  - Then -> SETUP, or -> RESP with BRESP=2'b10 if cmd_err. The W beat is always consumed, even for errored writes.
- SETUP: PSEL=1, PENABLE=0, PADDR=latched address, PWRITE=~read. Lasts exactly 1 cycle -> ACCESS.
- ACCESS: PSEL=1, PENABLE=1; PADDR, PWRITE, PWDATA and PSTRB are held stable.
  - PREADY=1: capture PRDATA (reads) and resp = PSLVERR ? 2'b10 : 2'b00. Deassert PSEL/PENABLE next cycle -> RESP.
  - PREADY=0: counter increments.
  - Counter reaches TIMEOUT-1 with PREADY still 0 (TIMEOUT≠0): drop PSEL/PENABLE, resp=2'b10, RDATA=0 -> RESP.
  - PREADY in the same cycle as the timeout wins: normal completion.
  - Counter clears on ACCESS entry.
- RESP:
  - BVALID (write) or RVALID (read) = 1 with captured ID and resp.
  - Held, with stable payload, until the ready handshake.
  - On handshake, finish_wr/finish_rd = BVALID&BREADY / RVALID&RREADY (combinational, 1 cycle) -> IDLE.
- Throughput: IDLE samples cmd_empty the cycle after the pop, so back-to-back commands have one IDLE cycle between the response handshake and the next SETUP/WDATA.
- Latency:
  - Read, PREADY tied high: cmd_empty low at cycle 0 -> SETUP 1, ACCESS 2, RVALID 3.
  - Write: WDATA at 1, SETUP one cycle after the W handshake.
- Never more than one outstanding command; finish_wr and finish_rd are never both high.
- PADDR/PWDATA hold their last values while idle; PSEL=0 marks them don't-care.

Test Plan:
- Read, PREADY=1, PRDATA=0xDEADBEEF, cmd_id=5, addr=0x0104 -> PSEL at cycle 1, PENABLE at 2, RVALID at 3; RDATA=0xDEADBEEF, RID=5, RRESP=0, RLAST=1; finish_rd 1 cycle on RREADY.
- Write with WVALID delayed 4 cycles, WDATA=0x12345678, WSTRB=0x3 -> WREADY held; SETUP follows the handshake; PWDATA=0x12345678, PSTRB=0x3, PWRITE=1; BRESP=0; finish_wr on BREADY.
- Read, PREADY low 3 cycles then high with PSLVERR=1 -> PENABLE high 4 cycles, address stable throughout, RRESP=2'b10.
- TIMEOUT=4, PREADY never asserted -> PSEL drops after 4 ACCESS cycles, RRESP=2'b10, RDATA=0; next command proceeds normally.
- cmd_err write -> W beat consumed, no PSEL pulse, BRESP=2'b10. cmd_err read -> no APB cycle, RVALID with RRESP=2'b10.
- rst asserted during ACCESS with BREADY=0 held -> all outputs 0 asynchronously, state IDLE, no finish pulse; after release the next command executes from SETUP cleanly.

Source files
------------

// File: rtl/axi2apb_ctrl.sv
// Purpose: pops one AXI command at a time and runs exactly one APB transfer for it,
//          then returns the response on B or R. A PREADY timeout bounds hung slaves.
// Latency: read with PREADY high has cmd_empty low at cycle 0, SETUP 1, ACCESS 2, RVALID 3.
//          A write adds the WDATA wait and then enters SETUP one cycle after the W handshake.
// Backpressure: WREADY is high only in WDATA. B/R are held with a stable payload until
//          ready. Only one command is in flight; the next pop waits for the handshake.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   cmd_*                         head of the command FIFO; finish_wr/finish_rd pop it
//   W*  / B* / R*                 AXI write-data, write-response and read-data channels
//   P*                            APB master interface
module axi2apb_ctrl #(
  parameter int AXI_ID_WIDTH   = 6,
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TIMEOUT        = 255,
  parameter int TIMEOUT_WIDTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_empty,
  input  logic                      cmd_read,
  input  logic [AXI_ID_WIDTH-1:0]   cmd_id,
  input  logic [APB_ADDR_WIDTH+3:0] cmd_addr,
  input  logic                      cmd_err,
  output logic                      finish_wr,
  output logic                      finish_rd,
  input  logic [31:0]               WDATA,
  input  logic [3:0]                WSTRB,
  input  logic                      WVALID,
  output logic                      WREADY,
  output logic [AXI_ID_WIDTH-1:0]   BID,
  output logic [1:0]                BRESP,
  output logic                      BVALID,
  input  logic                      BREADY,
  output logic [AXI_ID_WIDTH-1:0]   RID,
  output logic [31:0]               RDATA,
  output logic [1:0]                RRESP,
  output logic                      RLAST,
  output logic                      RVALID,
  input  logic                      RREADY,
  output logic [APB_ADDR_WIDTH+3:0] PADDR,
  output logic                      PSEL,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [31:0]               PWDATA,
  output logic [3:0]                PSTRB,
  input  logic                      PREADY,
  input  logic                      PSLVERR,
  input  logic [31:0]               PRDATA
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WDATA  = 3'd1,
    S_SETUP  = 3'd2,
    S_ACCESS = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [APB_ADDR_WIDTH+3:0] r_addr;
  logic                      r_read;
  logic                      r_err;
  logic [31:0]               r_pwdata;
  logic [3:0]                r_pstrb;
  logic [31:0]               r_rdata;
  logic [1:0]                r_resp;
  logic [TIMEOUT_WIDTH-1:0]  r_cnt;
  logic                      w_timeout;

  // Timeout fires on the last allowed ACCESS cycle; PREADY in that same cycle still wins
  // because the ACCESS branches below test PREADY first.
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == TIMEOUT_WIDTH'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    WREADY    = 1'b0;
    PSEL      = 1'b0;
    PENABLE   = 1'b0;
    BVALID    = 1'b0;
    RVALID    = 1'b0;
    finish_wr = 1'b0;
    finish_rd = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!cmd_empty) begin
          if (!cmd_read)    w_next = S_WDATA;
          else if (cmd_err) w_next = S_RESP;
          else              w_next = S_SETUP;
        end
      end
      S_WDATA: begin
        WREADY = 1'b1;
        // The W beat is consumed even for an errored write so the AXI side stays in step.
        if (WVALID) w_next = r_err ? S_RESP : S_SETUP;
      end
      S_SETUP: begin
        PSEL   = 1'b1;
        w_next = S_ACCESS;
      end
      S_ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        if (PREADY || w_timeout) w_next = S_RESP;
      end
      S_RESP: begin
        BVALID    = !r_read;
        RVALID    = r_read;
        finish_wr = !r_read && BREADY;
        finish_rd = r_read && RREADY;
        if (finish_wr || finish_rd) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id     <= '0;
      r_addr   <= '0;
      r_read   <= 1'b0;
      r_err    <= 1'b0;
      r_pwdata <= '0;
      r_pstrb  <= '0;
      r_rdata  <= '0;
      r_resp   <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!cmd_empty) begin
            r_id   <= cmd_id;
            r_addr <= cmd_addr;
            r_read <= cmd_read;
            r_err  <= cmd_err;
            // Unsupported read skips the APB cycle entirely.
            if (cmd_read && cmd_err) begin
              r_resp  <= 2'b10;
              r_rdata <= '0;
            end
          end
        end
        S_WDATA: begin
          if (WVALID) begin
            r_pwdata <= WDATA;
            r_pstrb  <= WSTRB;
            if (r_err) r_resp <= 2'b10;
          end
        end
        S_SETUP: begin
          r_cnt <= '0;
        end
        S_ACCESS: begin
          if (PREADY) begin
            if (r_read) r_rdata <= PRDATA;
            r_resp <= PSLVERR ? 2'b10 : 2'b00;
          end else if (w_timeout) begin
            r_resp  <= 2'b10;
            r_rdata <= '0;
          end else begin
            r_cnt <= r_cnt + TIMEOUT_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign PADDR  = r_addr;
  assign PWRITE = PSEL && !r_read;
  assign PWDATA = r_pwdata;
  assign PSTRB  = r_pstrb;
  assign BID    = r_id;
  assign RID    = r_id;
  assign BRESP  = r_resp;
  assign RRESP  = r_resp;
  assign RDATA  = r_rdata;
  assign RLAST  = 1'b1;

endmodule

// File: tb/tb_axi2apb_ctrl.sv
// Directed bench for axi2apb_ctrl with TIMEOUT=4. Inputs change and outputs are
// sampled on the falling edge; the DUT acts on the rising edge.
module tb_axi2apb_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_empty, cmd_read, cmd_err;
  logic [5:0]  cmd_id;
  logic [15:0] cmd_addr;
  logic        finish_wr, finish_rd;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID, WREADY;
  logic [5:0]  BID, RID;
  logic [1:0]  BRESP, RRESP;
  logic        BVALID, BREADY;
  logic [31:0] RDATA;
  logic        RLAST, RVALID, RREADY;
  logic [15:0] PADDR;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic        PREADY, PSLVERR;
  logic [31:0] PRDATA;

  int errors = 0;
  int checks = 0;
  int n_fin  = 0;

  axi2apb_ctrl #(
    .AXI_ID_WIDTH(6), .APB_ADDR_WIDTH(12), .TIMEOUT(4), .TIMEOUT_WIDTH(8)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_empty(cmd_empty), .cmd_read(cmd_read), .cmd_id(cmd_id),
    .cmd_addr(cmd_addr), .cmd_err(cmd_err),
    .finish_wr(finish_wr), .finish_rd(finish_rd),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
    .RVALID(RVALID), .RREADY(RREADY),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .PRDATA(PRDATA)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (finish_wr || finish_rd) n_fin++;
    if (finish_wr && finish_rd) begin
      errors++;
      $display("FAIL finish_exclusive: both finish_wr and finish_rd high at %0t", $time);
    end
  end

  typedef struct {
    logic        rd;
    logic        err;
    logic [5:0]  id;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] prdata;
    logic        slverr;
    int          wdelay;
    int          wait_c;     // ACCESS cycles with PREADY low before it rises
    logic        exp_psel;
    int          exp_pen;    // number of cycles PENABLE is seen high
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } txn_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outs(input string name);
    chk({name, " ctrl"}, 64'({PSEL, PENABLE, PWRITE, WREADY, BVALID, RVALID, finish_wr, finish_rd}), 64'd0);
    chk({name, " apb data"}, 64'({PADDR, PWDATA, PSTRB}), 64'd0);
    chk({name, " resp data"}, 64'({RDATA, BID, RID, BRESP, RRESP}), 64'd0);
    chk({name, " RLAST"}, 64'(RLAST), 64'd1);
  endtask

  task automatic run_txn(input int n, input txn_t t);
    int   pen;
    int   guard;
    logic psel_seen;
    logic bad;
    logic wr_held;
    string p;
    p = $sformatf("txn%0d", n);
    pen = 0; guard = 0; psel_seen = 1'b0; bad = 1'b0; wr_held = 1'b1;
    @(negedge clk);
    cmd_empty = 1'b0; cmd_read = t.rd; cmd_err = t.err; cmd_id = t.id; cmd_addr = t.addr;
    PRDATA = t.prdata; PSLVERR = t.slverr; PREADY = 1'b0;
    @(negedge clk);
    cmd_empty = 1'b1;
    if (!t.rd) begin
      for (int i = 0; i < t.wdelay; i++) begin
        if (WREADY !== 1'b1 || PSEL !== 1'b0) wr_held = 1'b0;
        @(negedge clk);
      end
      chk({p, " WREADY held"}, 64'(WREADY & wr_held), 64'd1);
      WVALID = 1'b1; WDATA = t.wdata; WSTRB = t.wstrb;
      @(negedge clk);
      WVALID = 1'b0; WDATA = 32'h0; WSTRB = 4'h0;
      chk({p, " WREADY after beat"}, 64'(WREADY), 64'd0);
    end
    chk({p, " PSEL at entry"}, 64'(PSEL), 64'(t.exp_psel));
    while (!(BVALID || RVALID) && guard < 40) begin
      if (PSEL) begin
        psel_seen = 1'b1;
        if (PADDR !== t.addr || PWRITE !== !t.rd) bad = 1'b1;
        if (!t.rd && (PWDATA !== t.wdata || PSTRB !== t.wstrb)) bad = 1'b1;
      end
      if (PENABLE) begin
        if (!PSEL) bad = 1'b1;
        PREADY = (pen >= t.wait_c);
        pen++;
      end else begin
        PREADY = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    PREADY = 1'b0;
    chk({p, " resp valid"}, 64'({BVALID, RVALID}), t.rd ? 64'd1 : 64'd2);
    chk({p, " psel seen"}, 64'(psel_seen), 64'(t.exp_psel));
    chk({p, " penable cycles"}, 64'(pen), 64'(t.exp_pen));
    chk({p, " apb stable"}, 64'(bad), 64'd0);
    if (t.rd) begin
      chk({p, " RID"}, 64'(RID), 64'(t.id));
      chk({p, " RRESP"}, 64'(RRESP), 64'(t.exp_resp));
      chk({p, " RDATA"}, 64'(RDATA), 64'(t.exp_rdata));
      chk({p, " RLAST"}, 64'(RLAST), 64'd1);
      RREADY = 1'b1;
    end else begin
      chk({p, " BID"}, 64'(BID), 64'(t.id));
      chk({p, " BRESP"}, 64'(BRESP), 64'(t.exp_resp));
      BREADY = 1'b1;
    end
    #1;
    chk({p, " finish pulse"}, 64'({finish_wr, finish_rd}), t.rd ? 64'd1 : 64'd2);
    @(negedge clk);
    RREADY = 1'b0; BREADY = 1'b0;
    chk({p, " after handshake"}, 64'({BVALID, RVALID, finish_wr, finish_rd, PSEL}), 64'd0);
  endtask

  txn_t tv[9];
  txn_t tr;
  int   fin_before;

  initial begin
    //        rd    err   id     addr      wdata         wstrb prdata        slv  wdl wait psel pen resp   rdata
    tv[0] = '{1'b1, 1'b0, 6'd5,  16'h0104, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 0, 0,  1'b1, 1, 2'b00, 32'hDEADBEEF};
    tv[1] = '{1'b0, 1'b0, 6'h21, 16'h0200, 32'h12345678, 4'h3, 32'h0,        1'b0, 4, 0,  1'b1, 1, 2'b00, 32'h0};
    tv[2] = '{1'b1, 1'b0, 6'd7,  16'h0ABC, 32'h0,        4'h0, 32'hCAFEF00D, 1'b1, 0, 3,  1'b1, 4, 2'b10, 32'hCAFEF00D};
    tv[3] = '{1'b1, 1'b0, 6'd9,  16'h0010, 32'h0,        4'h0, 32'h55555555, 1'b0, 0, 99, 1'b1, 4, 2'b10, 32'h0};
    tv[4] = '{1'b1, 1'b0, 6'd10, 16'h0020, 32'h0,        4'h0, 32'h0BADCAFE, 1'b0, 0, 3,  1'b1, 4, 2'b00, 32'h0BADCAFE};
    tv[5] = '{1'b0, 1'b1, 6'h3F, 16'hFFFF, 32'hAAAA5555, 4'hF, 32'h0,        1'b0, 0, 0,  1'b0, 0, 2'b10, 32'h0};
    tv[6] = '{1'b1, 1'b1, 6'd1,  16'h0300, 32'h0,        4'h0, 32'h77777777, 1'b0, 0, 0,  1'b0, 0, 2'b10, 32'h0};
    tv[7] = '{1'b0, 1'b0, 6'd2,  16'h0444, 32'h0F0F0F0F, 4'hC, 32'h0,        1'b1, 1, 2,  1'b1, 3, 2'b10, 32'h0};
    tv[8] = '{1'b0, 1'b0, 6'd3,  16'h0448, 32'h89ABCDEF, 4'h1, 32'h0,        1'b0, 0, 99, 1'b1, 4, 2'b10, 32'h0};

    rst = 1'b1;
    cmd_empty = 1'b1; cmd_read = 1'b0; cmd_err = 1'b0; cmd_id = '0; cmd_addr = '0;
    WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0; RREADY = 1'b0;
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
    #3;
    chk_reset_outs("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_txn(i, tv[i]);

    // Exact read latency with PREADY tied high, then a queued command showing the
    // single IDLE cycle between the handshake and the next SETUP.
    @(negedge clk);
    cmd_empty = 1'b0; cmd_read = 1'b1; cmd_err = 1'b0; cmd_id = 6'h2A; cmd_addr = 16'h0F00;
    PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = 32'h13572468;
    @(negedge clk);
    chk("lat c1 setup", 64'({PSEL, PENABLE, RVALID}), 64'b100);
    chk("lat c1 paddr", 64'(PADDR), 64'h0F00);
    cmd_id = 6'h2B; cmd_addr = 16'h0F04;
    @(negedge clk);
    chk("lat c2 access", 64'({PSEL, PENABLE, RVALID}), 64'b110);
    @(negedge clk);
    chk("lat c3 rvalid", 64'({PSEL, PENABLE, RVALID}), 64'b001);
    chk("lat c3 rdata", 64'({RID, RRESP, RDATA}), 64'({6'h2A, 2'b00, 32'h13572468}));
    RREADY = 1'b1;
    #1;
    chk("lat c3 finish", 64'({finish_wr, finish_rd}), 64'b01);
    @(negedge clk);
    RREADY = 1'b0;
    chk("b2b idle gap", 64'({PSEL, RVALID, finish_rd}), 64'd0);
    @(negedge clk);
    chk("b2b setup", 64'({PSEL, PENABLE}), 64'b10);
    chk("b2b paddr", 64'(PADDR), 64'h0F04);
    cmd_empty = 1'b1;
    @(negedge clk);
    chk("b2b access", 64'({PSEL, PENABLE}), 64'b11);
    @(negedge clk);
    chk("b2b rvalid", 64'({RVALID, RID}), 64'({1'b1, 6'h2B}));
    RREADY = 1'b1;
    @(negedge clk);
    RREADY = 1'b0;
    PREADY = 1'b0;

    // Asynchronous reset in the middle of an ACCESS phase of a write.
    fin_before = n_fin;
    @(negedge clk);
    cmd_empty = 1'b0; cmd_read = 1'b0; cmd_err = 1'b0; cmd_id = 6'h15; cmd_addr = 16'h0800;
    @(negedge clk);
    cmd_empty = 1'b1;
    WVALID = 1'b1; WDATA = 32'h11112222; WSTRB = 4'hF;
    @(negedge clk);
    WVALID = 1'b0;
    @(negedge clk);
    chk("pre-reset access", 64'({PSEL, PENABLE, PWRITE}), 64'b111);
    #2 rst = 1'b1;
    #1;
    chk_reset_outs("mid-access reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("no finish on abort", 64'(n_fin), 64'(fin_before));

    tr = '{1'b1, 1'b0, 6'h0C, 16'h0555, 32'h0, 4'h0, 32'hFEEDFACE, 1'b0, 0, 0, 1'b1, 1, 2'b00, 32'hFEEDFACE};
    run_txn(9, tr);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks);
    $fatal(1);
  end

endmodule
